reduce_tree_pipe: RTL and testbench

- Parametrised, pipelined bitwise reduction tree.
- Combines N_IN operands of WIDTH bits with a per-beat selectable operator (AND, OR, XOR, NAND).
- One register stage per tree level.
- Uses a valid/ready handshake on both sides, with full-pipeline stall under backpressure.
- Generalises the team's fixed four-input two-level AND network into a clocked, sized, multi-mode block, for use wherever wide reductions feed sequential logic.

---
 rtl/reduce_pkg.sv | 22 ++
 rtl/reduce_tree_pipe_if.sv | 24 ++
 rtl/reduce_stage.sv | 51 +++++
 rtl/reduce_tree_pipe.sv | 84 ++++++++
 tb/tb_reduce_tree_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reduce_pkg.sv
// Shared types and the per-bit pair operator for the pipelined reduction tree.
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  // NAND reduces as AND inside the tree; the inversion happens once at the output.
  function automatic logic apply_pair(op_e op, logic a, logic b);
    logic r;
    case (op)
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_if.sv
// Upstream beat and downstream result handshakes of the reduction tree.
interface reduce_tree_pipe_if #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 1
);
  logic [N_IN*WIDTH-1:0] in_data;
  logic [1:0]            in_op;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [1:0]            out_op;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_op, in_valid, out_ready,
    input  in_ready, out_data, out_op, out_valid
  );

  modport slave (
    input  in_data, in_op, in_valid, out_ready,
    output in_ready, out_data, out_op, out_valid
  );
endinterface

// File: rtl/reduce_stage.sv
// One registered tree level: combines adjacent operand pairs and carries valid/op.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int PAIRS = 1,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance_i,
  input  logic [2*PAIRS*WIDTH-1:0] data_i,
  input  logic                     valid_i,
  input  op_e                      op_i,
  output logic [PAIRS*WIDTH-1:0]   data_o,
  output logic                     valid_o,
  output op_e                      op_o
);

  logic [PAIRS*WIDTH-1:0] data_d;
  logic [PAIRS*WIDTH-1:0] data_q;
  logic                   valid_q;
  op_e                    op_q;

  always_comb begin
    // NOTE: default assignment first so no path through the block can infer a latch.
    data_d = '0;
    for (int p = 0; p < PAIRS; p++) begin
      for (int b = 0; b < WIDTH; b++) begin
        data_d[p*WIDTH+b] = apply_pair(op_i, data_i[2*p*WIDTH+b], data_i[(2*p+1)*WIDTH+b]);
      end
    end
  end

  // NOTE: data is reset along with valid so the visible result reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      op_q    <= OP_AND;
    end else if (advance_i) begin
      data_q  <= data_d;
      valid_q <= valid_i;
      op_q    <= op_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign op_o    = op_q;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined N_IN-operand bitwise reduction tree, one register level per tree level,
// with a single global advance that stalls the whole pipeline under backpressure.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  reduce_tree_pipe_if.slave   bus,
  output logic [15:0]         beat_count
);

  localparam int LEVELS = $clog2(N_IN);

  logic             advance;
  logic             last_valid;
  logic [WIDTH-1:0] last_data;
  op_e              last_op;
  logic [15:0]      beat_count_d;
  logic [15:0]      beat_count_q;

  assign advance     = !last_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int PAIRS = N_IN >> (k + 1);

    logic [2*PAIRS*WIDTH-1:0] src_data;
    logic                     src_valid;
    op_e                      src_op;
    logic [PAIRS*WIDTH-1:0]   stage_data;
    logic                     stage_valid;
    op_e                      stage_op;

    if (k == 0) begin : g_src_in
      assign src_data  = bus.in_data;
      assign src_valid = bus.in_valid;
      assign src_op    = op_e'(bus.in_op);
    end else begin : g_src_lvl
      assign src_data  = g_lvl[k-1].stage_data;
      assign src_valid = g_lvl[k-1].stage_valid;
      assign src_op    = g_lvl[k-1].stage_op;
    end

    reduce_stage #(
      .PAIRS (PAIRS),
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance_i (advance),
      .data_i    (src_data),
      .valid_i   (src_valid),
      .op_i      (src_op),
      .data_o    (stage_data),
      .valid_o   (stage_valid),
      .op_o      (stage_op)
    );
  end

  assign last_data  = g_lvl[LEVELS-1].stage_data;
  assign last_valid = g_lvl[LEVELS-1].stage_valid;
  assign last_op    = g_lvl[LEVELS-1].stage_op;

  // The last level holds the AND reduction for NAND beats; invert it on the way out.
  assign bus.out_data  = (last_op == OP_NAND) ? ~last_data : last_data;
  assign bus.out_op    = last_op;
  assign bus.out_valid = last_valid;

  assign beat_count_d = beat_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count_q <= '0;
    end else if (last_valid && bus.out_ready) begin
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Self-checking bench: three tree sizes against a queue-based reference model.
module tb_reduce_tree_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] bc0, bc1, bc2;

  reduce_tree_pipe_if #(.N_IN(4), .WIDTH(1)) if0 ();
  reduce_tree_pipe_if #(.N_IN(8), .WIDTH(4)) if1 ();
  reduce_tree_pipe_if #(.N_IN(2), .WIDTH(1)) if2 ();

  reduce_tree_pipe #(.N_IN(4), .WIDTH(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave), .beat_count(bc0));
  reduce_tree_pipe #(.N_IN(8), .WIDTH(4)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave), .beat_count(bc1));
  reduce_tree_pipe #(.N_IN(2), .WIDTH(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave), .beat_count(bc2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] op;
    int         acc_cyc;
    int         stalls;
  } exp_t;

  exp_t        exp_q [3][$];
  logic [5:0]  got_q [3][$];

  logic [31:0] drv_data  [3];
  logic [1:0]  drv_op    [3];
  logic        drv_valid [3];
  logic        drv_ready [3];

  logic        s_ov [3];
  logic        s_ir [3];
  logic [3:0]  s_od [3];
  logic [1:0]  s_oo [3];
  logic [15:0] s_bc [3];

  logic [15:0] model_bc   [3];
  int          acc_cnt    [3];
  int          stall_cnt  [3];
  logic        stall_prev [3];
  logic [3:0]  prev_od    [3];
  logic [1:0]  prev_oo    [3];

  int n_tests;
  int n_fail;
  int cyc;

  assign if0.in_data   = drv_data[0][3:0];
  assign if1.in_data   = drv_data[1];
  assign if2.in_data   = drv_data[2][1:0];
  assign if0.in_op     = drv_op[0];
  assign if1.in_op     = drv_op[1];
  assign if2.in_op     = drv_op[2];
  assign if0.in_valid  = drv_valid[0];
  assign if1.in_valid  = drv_valid[1];
  assign if2.in_valid  = drv_valid[2];
  assign if0.out_ready = drv_ready[0];
  assign if1.out_ready = drv_ready[1];
  assign if2.out_ready = drv_ready[2];

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 8 : 2;
  endfunction

  function automatic int w_of(input int d);
    return (d == 1) ? 4 : 1;
  endfunction

  function automatic int lv_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction

  // Plain per-operand reduction; NAND is the complement of the full AND.
  function automatic logic [3:0] ref_reduce(input int n, input int w, input logic [31:0] data,
                                            input logic [1:0] op);
    logic [3:0] acc;
    logic [3:0] opnd;
    logic [3:0] mask;
    mask = 4'((1 << w) - 1);
    acc  = (op == 2'd0 || op == 2'd3) ? 4'hF : 4'h0;
    for (int i = 0; i < n; i++) begin
      opnd = 4'(data >> (i * w)) & mask;
      case (op)
        2'd1:    acc = acc | opnd;
        2'd2:    acc = acc ^ opnd;
        default: acc = acc & opnd;
      endcase
    end
    if (op == 2'd3) acc = ~acc;
    return acc & mask;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic sample();
    s_ov[0] = if0.out_valid;  s_ov[1] = if1.out_valid;  s_ov[2] = if2.out_valid;
    s_ir[0] = if0.in_ready;   s_ir[1] = if1.in_ready;   s_ir[2] = if2.in_ready;
    s_od[0] = {3'b000, if0.out_data};
    s_od[1] = if1.out_data;
    s_od[2] = {3'b000, if2.out_data};
    s_oo[0] = if0.out_op;     s_oo[1] = if1.out_op;     s_oo[2] = if2.out_op;
    s_bc[0] = bc0;            s_bc[1] = bc1;            s_bc[2] = bc2;
  endtask

  // Runs at every falling edge: predicts what the next rising edge accepts/consumes.
  task automatic monitor();
    exp_t e;
    sample();
    for (int d = 0; d < 3; d++) begin
      check("in_ready_rule", d, 32'(s_ir[d]), 32'(!s_ov[d] || drv_ready[d]));
      check("beat_count", d, 32'(s_bc[d]), 32'(model_bc[d]));
      if (stall_prev[d]) begin
        check("stall_valid", d, 32'(s_ov[d]), 32'd1);
        check("stall_data", d, 32'(s_od[d]), 32'(prev_od[d]));
        check("stall_op", d, 32'(s_oo[d]), 32'(prev_oo[d]));
      end
      if (rst) begin
        exp_q[d].delete();
        model_bc[d]   = '0;
        acc_cnt[d]    = 0;
        stall_prev[d] = 1'b0;
        continue;
      end
      if (s_ov[d]) check("no_spurious_output", d, 32'(exp_q[d].size() != 0), 32'd1);
      if (s_ov[d] && drv_ready[d] && exp_q[d].size() != 0) begin
        e = exp_q[d].pop_front();
        check("out_data", d, 32'(s_od[d]), 32'(e.data));
        check("out_op", d, 32'(s_oo[d]), 32'(e.op));
        if (e.stalls == stall_cnt[d]) check("latency", d, 32'(cyc - e.acc_cyc), 32'(lv_of(d)));
        got_q[d].push_back({s_oo[d], s_od[d]});
        model_bc[d] = model_bc[d] + 16'd1;
      end
      if (!drv_ready[d]) stall_cnt[d]++;
      if (drv_valid[d] && s_ir[d]) begin
        e.data    = ref_reduce(n_of(d), w_of(d), drv_data[d], drv_op[d]);
        e.op      = drv_op[d];
        e.acc_cyc = cyc;
        e.stalls  = stall_cnt[d];
        exp_q[d].push_back(e);
        acc_cnt[d]++;
      end
      stall_prev[d] = s_ov[d] && !drv_ready[d];
      prev_od[d]    = s_od[d];
      prev_oo[d]    = s_oo[d];
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      drv_valid[d] = 1'b0;
      drv_ready[d] = 1'b1;
      drv_data[d]  = '0;
      drv_op[d]    = 2'd0;
    end
  endtask

  task automatic rand_beat(input int d);
    drv_data[d] = $urandom;
    drv_op[d]   = 2'($urandom_range(0, 3));
  endtask

  task automatic check_reset_state();
    sample();
    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", d, 32'(s_ov[d]), 32'd0);
      check("rst_beat_count", d, 32'(s_bc[d]), 32'd0);
      check("rst_in_ready", d, 32'(s_ir[d]), 32'd1);
      check("rst_out_data", d, 32'(s_od[d]), 32'd0);
      check("rst_out_op", d, 32'(s_oo[d]), 32'd0);
    end
  endtask

  logic [1:0] t2_ops  [4];
  logic [3:0] t2_data [4];
  logic [3:0] held;
  int         base;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    for (int d = 0; d < 3; d++) begin
      model_bc[d]   = '0;
      acc_cnt[d]    = 0;
      stall_cnt[d]  = 0;
      stall_prev[d] = 1'b0;
      prev_od[d]    = '0;
      prev_oo[d]    = '0;
    end
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    check_reset_state();
    rst = 1'b0;

    // Hand-computed anchors for the reference model.
    check("model_and_1111", 0, 32'(ref_reduce(4, 1, 32'hF, 2'd0)), 32'd1);
    check("model_and_0111", 0, 32'(ref_reduce(4, 1, 32'h7, 2'd0)), 32'd0);
    check("model_xor_8421", 1, 32'(ref_reduce(8, 4, 32'h0000_8421, 2'd2)), 32'hF);
    check("model_nand_8421", 1, 32'(ref_reduce(8, 4, 32'h0000_8421, 2'd3)), 32'hF);
    check("model_nand_11", 2, 32'(ref_reduce(2, 1, 32'h3, 2'd3)), 32'd0);

    // Test 1: four-input AND over every 4-bit pattern, one beat per cycle.
    got_q[0].delete();
    for (int i = 0; i < 16; i++) begin
      drv_valid[0] = 1'b1;
      drv_data[0]  = 32'(i);
      drv_op[0]    = 2'd0;
      tick();
    end
    drv_valid[0] = 1'b0;
    repeat (4) tick();
    check("t1_count", 0, 32'(got_q[0].size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q[0].size(); i++) begin
      base = 0;
      check("t1_and_result", 0, 32'(got_q[0][i][3:0]), 32'(i == 15));
    end

    // Test 2: eight 4-bit operands with the op changing every beat.
    t2_ops  = '{2'd2, 2'd1, 2'd0, 2'd3};
    t2_data = '{4'hF, 4'hF, 4'h0, 4'hF};
    got_q[1].delete();
    for (int i = 0; i < 4; i++) begin
      drv_valid[1] = 1'b1;
      drv_data[1]  = 32'h0000_8421;
      drv_op[1]    = t2_ops[i];
      tick();
    end
    drv_valid[1] = 1'b0;
    repeat (5) tick();
    check("t2_count", 1, 32'(got_q[1].size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q[1].size(); i++) begin
      check("t2_data", 1, 32'(got_q[1][i][3:0]), 32'(t2_data[i]));
      check("t2_op", 1, 32'(got_q[1][i][5:4]), 32'(t2_ops[i]));
    end

    // Test 3: five cycles of backpressure on a full pipeline.
    for (int i = 0; i < 6; i++) begin
      drv_valid[1] = 1'b1;
      rand_beat(1);
      tick();
    end
    drv_ready[1] = 1'b0;
    held = if1.out_data;
    for (int i = 0; i < 5; i++) begin
      rand_beat(1);
      tick();
      check("t3_in_ready_low", 1, 32'(if1.in_ready), 32'd0);
      check("t3_held_valid", 1, 32'(if1.out_valid), 32'd1);
      check("t3_held_data", 1, 32'(if1.out_data), 32'(held));
    end
    drv_ready[1] = 1'b1;
    drv_valid[1] = 1'b0;
    repeat (6) tick();
    check("t3_beat_count_eq_accepted", 1, 32'(bc1), 32'(acc_cnt[1]));
    check("t3_drained", 1, 32'(exp_q[1].size()), 32'd0);

    // Test 4: reset with beats in flight and a beat offered during reset.
    for (int d = 0; d < 3; d++) begin
      got_q[d].delete();
      drv_ready[d] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      for (int d = 0; d < 3; d++) begin
        drv_valid[d] = 1'b1;
        rand_beat(d);
      end
      tick();
    end
    rst = 1'b1;
    for (int d = 0; d < 3; d++) rand_beat(d);
    tick();
    rst = 1'b0;
    check_reset_state();
    idle_all();
    repeat (6) tick();
    for (int d = 0; d < 3; d++) check("t4_discarded", d, 32'(got_q[d].size()), 32'd0);

    // Randomised traffic with random backpressure on all three sizes.
    repeat (600) begin
      for (int d = 0; d < 3; d++) begin
        drv_valid[d] = ($urandom_range(0, 9) < 7);
        drv_ready[d] = ($urandom_range(0, 9) < 7);
        rand_beat(d);
      end
      tick();
    end
    idle_all();
    repeat (6) tick();

    // Test 5: two-input NAND result right after the accepting edge.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv_valid[2] = 1'b1;
    drv_data[2]  = 32'h3;
    drv_op[2]    = 2'd3;
    tick();
    sample();
    check("t5_nand_valid", 2, 32'(s_ov[2]), 32'd1);
    check("t5_nand_data", 2, 32'(s_od[2]), 32'd0);
    check("t5_nand_op", 2, 32'(s_oo[2]), 32'd3);
    drv_valid[2] = 1'b0;
    tick();

    // beat_count wrap: 65535 results, then one more.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (65535) begin
      drv_valid[2] = 1'b1;
      rand_beat(2);
      tick();
    end
    drv_valid[2] = 1'b0;
    tick();
    check("t5_count_ffff", 2, 32'(bc2), 32'h0000_FFFF);
    drv_valid[2] = 1'b1;
    rand_beat(2);
    tick();
    drv_valid[2] = 1'b0;
    tick();
    check("t5_count_wrap", 2, 32'(bc2), 32'd0);

    for (int d = 0; d < 3; d++) check("final_drained", d, 32'(exp_q[d].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
